// File: rtl/bconv_pkg.sv
// Shared constants and helpers for the binary convolution engine.
// Everything here is elaboration-time only; nothing in this file infers hardware.
package bconv_pkg;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_W = 3'd1;
    localparam logic [2:0] ST_RD_DIM = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_SKIP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [15:0] END_MARK_DEF = 16'h00FF;

    // Width of a match count. It must hold K*K, the count when every bit agrees.
    function automatic int match_w(input int k);
        return $clog2(k * k + 1);
    endfunction

    // The kernel has to fit in one weight word.
    function automatic bit legal_k(input int k, input int data_w);
        return (k >= 1) && (k <= 4) && (k * k <= data_w);
    endfunction

endpackage

// File: rtl/bconv_col_unit.sv
// One output column: XNOR the KxK window against the kernel, popcount the agreements,
// and compare the count with the threshold.
module bconv_col_unit
    import bconv_pkg::*;
#(
    parameter int K      = 3,
    parameter int THRESH = (K * K + 1) / 2
) (
    input  logic [K*K-1:0] win,
    input  logic [K*K-1:0] kern,
    output logic           col_bit
);

    localparam int MW = match_w(K);

    function automatic logic [MW-1:0] popcount(input logic [K*K-1:0] v);
        logic [MW-1:0] n;
        n = '0;
        for (int i = 0; i < K * K; i++) begin
            n = n + MW'(v[i]);
        end
        return n;
    endfunction

    logic [MW-1:0] match;

    assign match   = popcount(~(win ^ kern));
    assign col_bit = (match >= MW'(THRESH));

endmodule

// File: rtl/bconv_engine.sv
// Binary KxK convolution engine. It streams square images from the input SRAM and
// writes one packed output row per window position to the output SRAM.
module bconv_engine
    import bconv_pkg::*;
#(
    parameter int               ADDR_W   = 12,
    parameter int               DATA_W   = 16,
    parameter int               K        = 3,
    parameter int               THRESH   = (K * K + 1) / 2,
    parameter logic [DATA_W-1:0] END_MARK = DATA_W'(END_MARK_DEF)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable
);

    localparam int NCOL = DATA_W - K + 1;

    if (!legal_k(K, DATA_W)) begin : g_bad_k
        $error("bconv_engine: K must be 1..4 with K*K <= DATA_W");
    end

    logic [2:0]        state;
    logic              dim_wait;
    logic              ld_kern_p1;
    logic              vld_p1;
    logic              vld_p2;
    logic [DATA_W-1:0] dim;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] row_p1;
    logic [K*K-1:0]    kern;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] rows_q [K];
    logic [NCOL-1:0]   col_bits;
    logic              row_issue_p0;
    logic              issue_p0;
    logic              unused_wmem;

    assign row_issue_p0 = (state == ST_STREAM) && (cnt != dim);
    assign issue_p0     = ((state == ST_STREAM || state == ST_SKIP) && (cnt != dim))
                        || (state == ST_RD_DIM && !dim_wait);

    assign dut_sram_read_address  = rd_addr;
    assign dut_wmem_read_address  = '0;
    assign dut_sram_write_address = wr_addr;
    assign dut_sram_write_enable  = vld_p2;
    assign unused_wmem            = ^wmem_dut_read_data;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= ST_IDLE;
            dut_busy   <= 1'b0;
            dim_wait   <= 1'b0;
            ld_kern_p1 <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            dim        <= '0;
            cnt        <= '0;
            row_p1     <= '0;
            kern       <= '0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            for (int i = 0; i < K; i++) rows_q[i] <= '0;
        end else begin
            // p0 -> p1: the read issued last cycle has its data on the bus now
            ld_kern_p1 <= (state == ST_LOAD_W);
            if (ld_kern_p1) kern <= wmem_dut_read_data[K*K-1:0];
            vld_p1 <= row_issue_p0;
            if (row_issue_p0) row_p1 <= cnt;
            if (issue_p0) rd_addr <= rd_addr + ADDR_W'(1);

            // p1 -> p2: returned row enters the window; a full window becomes a write
            if (vld_p1) begin
                for (int i = 0; i < K - 1; i++) rows_q[i] <= rows_q[i+1];
                rows_q[K-1] <= sram_dut_read_data;
            end
            vld_p2 <= vld_p1 && (row_p1 >= DATA_W'(K - 1));
            if (vld_p2) wr_addr <= wr_addr + ADDR_W'(1);

            case (state)
                ST_IDLE: begin
                    if (dut_run) begin
                        state    <= ST_LOAD_W;
                        dut_busy <= 1'b1;
                        rd_addr  <= '0;
                        wr_addr  <= '0;
                    end
                end
                ST_LOAD_W: begin
                    state    <= ST_RD_DIM;
                    dim_wait <= 1'b0;
                end
                ST_RD_DIM: begin
                    if (!dim_wait) begin
                        dim_wait <= 1'b1;
                    end else begin
                        // The previous image's last row was consumed last cycle, so clearing here is safe.
                        dim_wait <= 1'b0;
                        dim      <= sram_dut_read_data;
                        cnt      <= '0;
                        for (int i = 0; i < K; i++) rows_q[i] <= '0;
                        if (sram_dut_read_data == END_MARK || sram_dut_read_data > DATA_W'(DATA_W))
                            state <= ST_DONE;
                        else if (sram_dut_read_data >= DATA_W'(K))
                            state <= ST_STREAM;
                        else
                            state <= ST_SKIP;
                    end
                end
                ST_STREAM, ST_SKIP: begin
                    if (cnt == dim) begin
                        state <= ST_RD_DIM;
                    end else begin
                        cnt <= cnt + DATA_W'(1);
                        if (cnt + DATA_W'(1) == dim) state <= ST_RD_DIM;
                    end
                end
                ST_DONE: begin
                    if (!vld_p1 && !vld_p2) begin
                        dut_busy <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p2: column units evaluate the registered window
    for (genvar c = 0; c < NCOL; c++) begin : g_col
        logic [K*K-1:0] win;
        for (genvar r = 0; r < K; r++) begin : g_row
            assign win[r*K +: K] = rows_q[r][c +: K];
        end
        bconv_col_unit #(.K(K), .THRESH(THRESH)) u_col (
            .win     (win),
            .kern    (kern),
            .col_bit (col_bits[c])
        );
    end

    // dim still describes the image being written, even during the dimension-evaluation cycle.
    always_comb begin
        dut_sram_write_data = '0;
        for (int c = 0; c < NCOL; c++) begin
            dut_sram_write_data[c] = col_bits[c] && (dim >= DATA_W'(c + K));
        end
    end

endmodule
